// File: rtl/median_filter_pkg.sv
// Shared pixel types for the median filter pipeline.
package median_filter_pkg;
  localparam int PIXEL_W = 8;

  typedef struct packed {
    logic [PIXEL_W-1:0] red;
    logic [PIXEL_W-1:0] green;
    logic [PIXEL_W-1:0] blue;
  } pixel_t;
endpackage

// File: rtl/pixel_valid_if.sv
// Valid-only pixel stream out of the median filter; the consumer cannot stall it.
interface pixel_valid_if;
  import median_filter_pkg::*;

  logic   valid;
  pixel_t pixel;

  modport master (output valid, output pixel);
  modport slave  (input valid, input pixel);
endinterface

// File: rtl/median_out_framer.sv
// Tags filtered pixels with sof/eol/eof by frame position and buffers them in a FWFT FIFO, one cycle write-to-output.
// The input cannot be stalled: a pixel arriving at a full FIFO with no read is dropped and overflow_o sticks.
module median_out_framer
  import median_filter_pkg::*;
#(
  parameter int OUT_LEN    = 1079,
  parameter int OUT_HEIGHT = 719,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  pixel_valid_if.slave  pixel_valid_if_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output pixel_t        m_pixel_o,
  output logic          m_sof_o,
  output logic          m_eol_o,
  output logic          m_eof_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    pixel_t pixel;
    logic   sof;
    logic   eol;
    logic   eof;
  } entry_t;

  state_t        state_q;
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          busy_q, frame_done_q, overflow_q;

  logic   empty, full, rd_fire, in_fire, wr_ok, col_last, row_last;
  entry_t head, wr_entry;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_fire  = !empty && m_ready_i;
  assign in_fire  = (state_q == ACTIVE) && pixel_valid_if_i.valid;
  // A read in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign wr_ok    = in_fire && (!full || rd_fire);
  assign col_last = (col_q == CW'(OUT_LEN - 1));
  assign row_last = (row_q == RW'(OUT_HEIGHT - 1));

  always_comb begin
    wr_entry.pixel = pixel_valid_if_i.pixel;
    wr_entry.sof   = (col_q == '0) && (row_q == '0);
    wr_entry.eol   = col_last;
    wr_entry.eof   = col_last && row_last;
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_last) begin
      col_d = '0;
      row_d = row_last ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_ok)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= ACTIVE;
            busy_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (in_fire) begin
            if (!wr_ok) overflow_q <= 1'b1;
            col_q <= col_d;
            row_q <= row_d;
            if (col_last && row_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // An empty FIFO here means the eof pixel itself was dropped.
          if ((rd_fire && head.eof) || empty) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid_o    = !empty;
  assign m_pixel_o    = empty ? '0 : head.pixel;
  assign m_sof_o      = !empty && head.sof;
  assign m_eol_o      = !empty && head.eol;
  assign m_eof_o      = !empty && head.eof;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_median_out_framer.sv
// Directed table-driven bench for median_out_framer on a 4x3 frame with a 4-entry FIFO.
module tb_median_out_framer;
  import median_filter_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   start_i;
  logic   m_valid_o, m_ready_i, m_sof_o, m_eol_o, m_eof_o;
  logic   busy_o, frame_done_o, overflow_o;
  pixel_t m_pixel_o;
  int     n_chk  = 0;
  int     n_fail = 0;

  pixel_valid_if vif ();

  median_out_framer #(.OUT_LEN(4), .OUT_HEIGHT(3), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .pixel_valid_if_i (vif),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .m_pixel_o        (m_pixel_o),
    .m_sof_o          (m_sof_o),
    .m_eol_o          (m_eol_o),
    .m_eof_o          (m_eof_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, vld, rdy;
    logic [23:0] pix;
    logic        e_vld;
    logic [23:0] e_pix;
    logic        e_sof, e_eol, e_eof, e_busy, e_done, e_ovf;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic s, v, input logic [23:0] p, input logic r,
                              input logic ev, input logic [23:0] ep,
                              input logic es, el, ef, eb, ed, eo);
    vec_t t;
    t.start = s; t.vld = v; t.pix = p; t.rdy = r;
    t.e_vld = ev; t.e_pix = ep; t.e_sof = es; t.e_eol = el; t.e_eof = ef;
    t.e_busy = eb; t.e_done = ed; t.e_ovf = eo;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the edge they acted on.
  task automatic cyc(input logic s, input logic v, input logic [23:0] p, input logic r);
    start_i   = s;
    vif.valid = v;
    vif.pixel = pixel_t'(p);
    m_ready_i = r;
    @(posedge clk);
    #1;
  endtask

  // Stream pixel k with ready high; it must appear alone at the head next cycle.
  task automatic send_check(input int k, input logic s);
    cyc(s, 1'b1, 24'(k), 1'b1);
    chk($sformatf("px%0d_vld", k), 32'(m_valid_o), 32'd1);
    chk($sformatf("px%0d_pix", k), {8'h0, m_pixel_o}, 32'(k));
    chk($sformatf("px%0d_sof", k), 32'(m_sof_o), 32'(k == 1));
    chk($sformatf("px%0d_eol", k), 32'(m_eol_o), 32'(k % 4 == 0));
    chk($sformatf("px%0d_eof", k), 32'(m_eof_o), 32'(k == 12));
  endtask

  task automatic finish_frame(input string tag, input logic exp_ovf);
    cyc(1'b0, 1'b0, 24'h0, 1'b1);
    chk({tag, "_done"}, 32'(frame_done_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_vld"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    cyc(1'b0, 1'b0, 24'h0, 1'b1);
    chk({tag, "_done_once"}, 32'(frame_done_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; vif.valid = 1'b0; vif.pixel = '0; m_ready_i = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      start_i   = 1'($urandom);
      vif.valid = 1'($urandom);
      vif.pixel = pixel_t'($urandom);
      m_ready_i = 1'($urandom);
      @(posedge clk);
    end
    #1;
    chk("rst_vld", 32'(m_valid_o), 0);
    chk("rst_pix", {8'h0, m_pixel_o}, 0);
    chk("rst_sof", 32'(m_sof_o), 0);
    chk("rst_eol", 32'(m_eol_o), 0);
    chk("rst_eof", 32'(m_eof_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(frame_done_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 24'h0, 1'b0);

    // Nominal frame plus ignored IDLE input, table-driven
    tbl[0] = mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++)
      tbl[k] = mk(0, 1, 24'(k), 1, 1, 24'(k), k == 1, k % 4 == 0, k == 12, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 1,       0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 1,       0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 24'h55, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 24'h66, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].start, tbl[i].vld, tbl[i].pix, tbl[i].rdy);
      chk($sformatf("t%0d_vld", i), 32'(m_valid_o), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d_pix", i), {8'h0, m_pixel_o}, {8'h0, tbl[i].e_pix});
      chk($sformatf("t%0d_sof", i), 32'(m_sof_o), 32'(tbl[i].e_sof));
      chk($sformatf("t%0d_eol", i), 32'(m_eol_o), 32'(tbl[i].e_eol));
      chk($sformatf("t%0d_eof", i), 32'(m_eof_o), 32'(tbl[i].e_eof));
      chk($sformatf("t%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("t%0d_done", i), 32'(frame_done_o), 32'(tbl[i].e_done));
      chk($sformatf("t%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].e_ovf));
    end

    // Overflow: six pixels into a stalled 4-entry FIFO
    cyc(1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b1, 24'(k), 1'b0);
      chk($sformatf("ovf_p%0d_head", k), {8'h0, m_pixel_o}, 32'd1);
      chk($sformatf("ovf_p%0d_flag", k), 32'(overflow_o), 32'(k >= 5));
    end
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("ovf_b%0d_vld", b), 32'(m_valid_o), 32'd1);
      chk($sformatf("ovf_b%0d_pix", b), {8'h0, m_pixel_o}, 32'(b + 1));
      chk($sformatf("ovf_b%0d_sof", b), 32'(m_sof_o), 32'(b == 0));
      chk($sformatf("ovf_b%0d_eol", b), 32'(m_eol_o), 32'(b == 3));
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
    end
    chk("ovf_drained", 32'(m_valid_o), 32'd0);
    for (int k = 7; k <= 12; k++) send_check(k, 1'b0);
    finish_frame("ovf_end", 1'b1);

    // Full FIFO accepting a write alongside a read
    cyc(1'b1, 1'b0, 24'h0, 1'b0);
    chk("full_ovf_cleared", 32'(overflow_o), 32'd0);
    for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b1, 24'(k), 1'b0);
    cyc(1'b0, 1'b1, 24'd5, 1'b1);
    chk("full_rw_ovf", 32'(overflow_o), 32'd0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("full_b%0d_vld", b), 32'(m_valid_o), 32'd1);
      chk($sformatf("full_b%0d_pix", b), {8'h0, m_pixel_o}, 32'(b + 2));
      chk($sformatf("full_b%0d_eol", b), 32'(m_eol_o), 32'(b == 2));
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
    end
    chk("full_drained", 32'(m_valid_o), 32'd0);
    for (int k = 6; k <= 12; k++) send_check(k, 1'b0);
    finish_frame("full_end", 1'b0);

    // start_i mid-ACTIVE must not disturb positional tags
    cyc(1'b1, 1'b0, 24'h0, 1'b1);
    for (int k = 1; k <= 12; k++) send_check(k, k == 3 || k == 6);
    finish_frame("midstart_end", 1'b0);

    // Reset mid-frame with stalled data, then a clean frame
    cyc(1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b1, 24'(k + 32), 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 24'h0, 1'b0);
    rst = 1'b0;
    chk("mrst_vld", 32'(m_valid_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_ovf", 32'(overflow_o), 32'd0);
    cyc(1'b1, 1'b0, 24'h0, 1'b1);
    chk("mrst_start_vld", 32'(m_valid_o), 32'd0);
    for (int k = 1; k <= 12; k++) send_check(k, 1'b0);
    finish_frame("mrst_end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/median_out_framer.md
Name: median_out_framer

Overview:
- Sits directly downstream of the median filter.
- Takes its valid-only filtered pixel stream (no backpressure) and buffers it in a small FIFO.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame markers from its position in the (IMAGE_LEN-1) x (IMAGE_HEIGHT-1) output frame.
- Presents the tagged pixels on a valid/ready stream to the sink, and reports frame completion plus sticky overflow.

Parameters:
- OUT_LEN, 1079, pixels per output line (median filter IMAGE_LEN-1).
- OUT_HEIGHT, 719, lines per output frame (median filter IMAGE_HEIGHT-1).
- FIFO_DEPTH, 16, buffered entries; power of two, >=2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- start_i  input  1  arms the block for one frame.
- pixel_valid_if_i  slave modport  pixel_valid_if  filtered pixel in; valid + pixel_t {red,green,blue}, each median_filter_pkg::PIXEL_W bits.
- m_valid_o  output  1  output beat valid.
- m_ready_i  input  1  sink ready.
- m_pixel_o  output  pixel_t  output pixel.
- m_sof_o  output  1  first pixel of frame.
- m_eol_o  output  1  last pixel of a line.
- m_eof_o  output  1  last pixel of frame.
- busy_o  output  1  high in ACTIVE or DRAIN.
- frame_done_o  output  1  one-cycle pulse at frame completion.
- overflow_o  output  1  sticky: a pixel was dropped.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE, FIFO empty, counters 0.
  - All outputs 0: m_valid_o, m_pixel_o, m_sof_o, m_eol_o, m_eof_o, busy_o, frame_done_o, overflow_o.
  - Reset mid-frame discards all buffered data and counters immediately.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - Input valid ignored; not counted, not flagged as overflow.
  - start_i=1 -> ACTIVE; clears col/row counters and overflow_o.
- ACTIVE:
  - Each cycle with input valid=1 is one input pixel at position (col,row).
  - col increments; wraps to 0 at OUT_LEN-1, then row increments.
  - Entry written = {pixel, sof = (col==0 && row==0), eol = (col==OUT_LEN-1), eof = eol && row==OUT_HEIGHT-1}.
  - On the input carrying eof, go to DRAIN.
  - start_i is ignored in ACTIVE and DRAIN.
- DRAIN:
  - Input valid ignored.
  - When the entry with eof handshakes (m_valid_o && m_ready_i), go to IDLE.
  - frame_done_o=1 in the following cycle only.
- FIFO:
  - First-word-fall-through; m_valid_o = !empty; m_pixel_o and tags show the head entry.
  - Read occurs on m_valid_o && m_ready_i.
  - Latency: a pixel written in cycle N is visible on the outputs in cycle N+1. There is no combinational input-to-output path, including when the FIFO is empty.
  - Full with no read in the same cycle: incoming pixel dropped and overflow_o set (sticky until next start_i or rst). col/row still advance, so later tags stay positional.
  - Full with a read in the same cycle: write accepted, no overflow.
  - Simultaneous read and write otherwise: occupancy unchanged.
  - Output-side protocol: m_pixel_o and tags hold stable while m_valid_o=1 && m_ready_i=0.
- Pointers: $clog2(FIFO_DEPTH) bits plus one extra wrap bit for the full/empty distinction.
- Counters: col is $clog2(OUT_LEN) bits; row is $clog2(OUT_HEIGHT) bits.
- Corner case: if the eof pixel itself is dropped by overflow, DRAIN exits when the FIFO becomes empty. frame_done_o still pulses once.

Test Plan (OUT_LEN=4, OUT_HEIGHT=3, FIFO_DEPTH=4 unless noted):
1. Reset: hold rst 2 cycles with random inputs -> all outputs 0, busy_o=0.
2. Nominal frame: start_i, then 12 back-to-back pixels 0x000001..0x00000C, m_ready_i=1.
   - 12 beats in order, each one cycle after its input.
   - sof on beat 0; eol on beats 3,7,11; eof on beat 11.
   - frame_done_o pulses the cycle after beat 11; busy_o falls with it; overflow_o=0.
3. Overflow: start_i, m_ready_i=0, 6 pixels.
   - First 4 stored; overflow_o=1 the cycle after pixel 5.
   - Raise m_ready_i -> beats 1-4 only; beat 3 eol=1.
   - Pixels 7-12 then give eol on pixels 8 and 12, and eof on pixel 12.
4. Full + simultaneous read: fill 4 entries, then a pixel arrives in the same cycle as a handshake -> accepted, overflow_o stays 0, occupancy stays 4.
5. Ignored inputs:
   - Valid pixels in IDLE produce no beats.
   - start_i pulsed mid-ACTIVE does not reset col/row; tags are unchanged.
6. Reset mid-frame after 5 pixels with m_ready_i=0, then start_i and a full 12-pixel frame -> only the new 12 beats appear, sof on the first.
